// File: rtl/wb2apb_wide.sv
// wb2apb_wide: Wishbone classic slave to APB3/APB4 master bridge splitting each WB access into RATIO narrower APB beats
module wb2apb_wide #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int RATIO          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                rstn_i,
    input  logic                                wb_cyc_i,
    input  logic                                wb_stb_i,
    input  logic                                wb_we_i,
    input  logic [APB_ADDR_WIDTH-1:0]           wb_adr_i,
    input  logic [APB_DATA_WIDTH*RATIO-1:0]     wb_dat_i,
    input  logic [APB_DATA_WIDTH*RATIO/8-1:0]   wb_sel_i,
    output logic [APB_DATA_WIDTH*RATIO-1:0]     wb_dat_o,
    output logic                                wb_ack_o,
    output logic                                wb_err_o,
    output logic                                psel_o,
    output logic                                penable_o,
    output logic                                pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    output logic [APB_DATA_WIDTH/8-1:0]         pstrb_o,
    input  logic [APB_DATA_WIDTH-1:0]           prdata_i,
    input  logic                                pready_i,
    input  logic                                pslverr_i
);
    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int WW = DW * RATIO;
    localparam int SW = DW / 8;
    localparam int WS = WW / 8;
    localparam int BW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] beat, beat_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [AW-1:0] adr, adr_n;
    logic          we, we_n;
    logic [WW-1:0] dat, dat_n, rbuf, rbuf_n;
    logic [WS-1:0] sel, sel_n;
    logic          ack_n, err_n, last;
    logic          psel_n, pen_n, pwrite_n;
    logic [AW-1:0] paddr_n;
    logic [DW-1:0] pwdata_n;
    logic [SW-1:0] pstrb_n;
    logic [WW-1:0] rdat_n;

    assign last = beat == BW'(RATIO - 1);

    // Sequencer: request capture, beat stepping, error/timeout abort and WB cycle withdrawal
    always_comb begin
        state_n = state;
        beat_n  = beat;
        tcnt_n  = tcnt;
        adr_n   = adr;
        we_n    = we;
        dat_n   = dat;
        sel_n   = sel;
        rbuf_n  = rbuf;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (wb_cyc_i && wb_stb_i) begin
                state_n = SETUP;
                beat_n  = '0;
                adr_n   = wb_adr_i;
                we_n    = wb_we_i;
                dat_n   = wb_dat_i;
                sel_n   = wb_sel_i;
                rbuf_n  = '0;
            end
            SETUP: begin
                state_n = ACCESS;
                tcnt_n  = '0;
            end
            ACCESS: if (pready_i) begin
                if (!pslverr_i && !we)
                    rbuf_n = rbuf | (WW'(prdata_i) << (DW * int'(beat)));
                if (!wb_cyc_i) begin
                    state_n = IDLE;
                end else if (pslverr_i || last) begin
                    state_n = RESP;
                    err_n   = pslverr_i;
                    ack_n   = !pslverr_i;
                end else begin
                    state_n = SETUP;
                    beat_n  = beat + BW'(1);
                end
            end else begin
                tcnt_n = tcnt + TW'(1);
                if (TIMEOUT_CYCLES != 0 && tcnt_n == TW'(TIMEOUT_CYCLES)) begin
                    state_n = wb_cyc_i ? RESP : IDLE;
                    err_n   = wb_cyc_i;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are derived from the next state so they can be registered without extra latency
    assign psel_n   = state_n == SETUP || state_n == ACCESS;
    assign pen_n    = state_n == ACCESS;
    assign pwrite_n = psel_n && we_n;
    assign paddr_n  = psel_n ? adr_n + AW'(beat_n) * AW'(SW) : '0;
    assign pwdata_n = psel_n ? DW'(dat_n >> (DW * int'(beat_n))) : '0;
    assign pstrb_n  = pwrite_n ? SW'(sel_n >> (SW * int'(beat_n))) : '0;
    assign rdat_n   = (ack_n || err_n) ? rbuf_n : '0;

    // State, captured request and all registered WB/APB outputs
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            beat      <= '0;
            tcnt      <= '0;
            adr       <= '0;
            we        <= 1'b0;
            dat       <= '0;
            sel       <= '0;
            rbuf      <= '0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pstrb_o   <= '0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            tcnt      <= tcnt_n;
            adr       <= adr_n;
            we        <= we_n;
            dat       <= dat_n;
            sel       <= sel_n;
            rbuf      <= rbuf_n;
            wb_dat_o  <= rdat_n;
            wb_ack_o  <= ack_n;
            wb_err_o  <= err_n;
            psel_o    <= psel_n;
            penable_o <= pen_n;
            pwrite_o  <= pwrite_n;
            paddr_o   <= paddr_n;
            pwdata_o  <= pwdata_n;
            pstrb_o   <= pstrb_n;
        end
    end
endmodule

// File: tb/tb_wb2apb_wide.sv
// tb_wb2apb_wide: table-driven and randomized checks of the WB-to-APB width-converting bridge
module tb_wb2apb_wide;
    localparam int TO = 4;

    logic        clk;
    logic        rstn_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i;
    logic [63:0] wb_dat_i;
    logic [7:0]  wb_sel_i;
    logic [63:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o, pwdata_o;
    logic [3:0]  pstrb_o;
    logic [31:0] prdata_i;
    logic        pready_i, pslverr_i;

    wb2apb_wide #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .RATIO(2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstn_i(rstn_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One WB access plus the APB slave behaviour for each of its two beats and the expected outcome
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [63:0] dat;
        logic [7:0]  sel;
        int          w0, w1;
        logic        e0, e1;
        logic [31:0] r0, r1;
        logic        x_err;
        int          x_lat;
        int          x_pen;
        int          x_beats;
        logic [63:0] x_rd;
    } vec_t;

    vec_t tab [9];
    vec_t rv;
    int   checks, errors;
    int   nb_d;
    bit   resp_d;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Outcome from the transfer rules: beats run in order, a slave error or a timeout ends the access
    function automatic vec_t model(input vec_t v);
        int          w [2];
        logic        e [2];
        logic [31:0] r [2];
        w[0] = v.w0; w[1] = v.w1; e[0] = v.e0; e[1] = v.e1; r[0] = v.r0; r[1] = v.r1;
        v.x_err = 1'b0; v.x_lat = 1; v.x_pen = 0; v.x_beats = 0; v.x_rd = '0;
        for (int b = 0; b < 2; b++) begin
            v.x_beats++;
            if (w[b] >= TO) begin
                v.x_lat += 1 + TO;
                v.x_pen += TO;
                v.x_err = 1'b1;
                break;
            end
            v.x_lat += 2 + w[b];
            v.x_pen += 1 + w[b];
            if (e[b]) begin
                v.x_err = 1'b1;
                break;
            end
            if (!v.we) v.x_rd[32*b +: 32] = r[b];
        end
        return v;
    endfunction

    task automatic run(input vec_t v, input string nm);
        int          nb, pen, acnt, lat, w;
        bit          done, a, e, stab;
        logic [63:0] rd;
        logic [68:0] cur, now_b, exp_b;
        logic [68:0] got [2];
        got[0] = '0; got[1] = '0; cur = '0; stab = 1; nb = 0; pen = 0; acnt = 0;
        done = 0; a = 0; e = 0; rd = '0; lat = 0;
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = v.we; wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            now_b = {paddr_o, pwdata_o, pstrb_o, pwrite_o};
            wb_adr_i = $urandom; wb_dat_i = {$urandom, $urandom}; wb_sel_i = 8'($urandom); wb_we_i = 1'($urandom);
            if (wb_ack_o || wb_err_o) begin
                done = 1; lat = c; a = wb_ack_o; e = wb_err_o; rd = wb_dat_o;
                wb_cyc_i = 0; wb_stb_i = 0; pready_i = 0; pslverr_i = 0;
            end else if (psel_o && !penable_o) begin
                cur = now_b;
                if (nb < 2) got[nb] = now_b;
                nb++; acnt = 0; pready_i = 0; pslverr_i = 0;
            end else if (psel_o) begin
                pen++;
                if (now_b != cur) stab = 0;
                w = nb == 1 ? v.w0 : v.w1;
                if (acnt == w) begin
                    pready_i = 1; prdata_i = nb == 1 ? v.r0 : v.r1; pslverr_i = nb == 1 ? v.e0 : v.e1;
                end else begin
                    pready_i = 0; prdata_i = $urandom; pslverr_i = 1'($urandom);
                end
                acnt++;
            end else begin
                pready_i = 0; pslverr_i = 0;
            end
        end
        chk({nm, "_done"}, 160'(done), 160'(1));
        chk({nm, "_resp"}, 160'({a, e}), 160'({~v.x_err, v.x_err}));
        chk({nm, "_lat"}, 160'(lat), 160'(v.x_lat));
        chk({nm, "_pen"}, 160'(pen), 160'(v.x_pen));
        chk({nm, "_beats"}, 160'(nb), 160'(v.x_beats));
        for (int b = 0; b < v.x_beats; b++) begin
            exp_b = {v.adr + 32'(4 * b), v.dat[32*b +: 32], v.we ? v.sel[4*b +: 4] : 4'h0, v.we};
            chk($sformatf("%s_beat%0d", nm, b), 160'(got[b]), 160'(exp_b));
        end
        chk({nm, "_stable"}, 160'(stab), 160'(1));
        if (!v.we) chk({nm, "_rdata"}, 160'(rd), 160'(v.x_rd));
        @(negedge clk);
        chk({nm, "_pulse"}, 160'({wb_ack_o, wb_err_o, psel_o, penable_o}), 160'(0));
    endtask

    initial begin
        checks = 0; errors = 0;
        rstn_i = 0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
        prdata_i = 0; pready_i = 0; pslverr_i = 0;
        //           we  adr       dat                    sel    w0 w1 e0 e1 r0            r1            err lat pen beats rdata
        tab[0] = '{1'b1, 32'h100, 64'h11223344_55667788, 8'hFF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 5, 2, 2, 64'h0};
        tab[1] = '{1'b0, 32'h200, 64'h0,                 8'hFF, 0, 2, 0, 0, 32'hAAAA0000, 32'h0000BBBB, 0, 7, 4, 2, 64'h0000BBBB_AAAA0000};
        tab[2] = '{1'b1, 32'h300, 64'hCAFEBABE_01020304, 8'hFF, 0, 0, 1, 0, 32'h0,        32'h0,        1, 3, 1, 1, 64'h0};
        tab[3] = '{1'b0, 32'h400, 64'h0,                 8'hFF, 4, 0, 0, 0, 32'h5555AAAA, 32'h0,        1, 6, 4, 1, 64'h0};
        tab[4] = '{1'b1, 32'h500, 64'hDEADBEEF_CAFEF00D, 8'h0F, 0, 0, 0, 0, 32'h0,        32'h0,        0, 5, 2, 2, 64'h0};
        tab[5] = '{1'b0, 32'h508, 64'h0,                 8'h0F, 0, 0, 0, 0, 32'h12345678, 32'h9ABCDEF0, 0, 5, 2, 2, 64'h9ABCDEF0_12345678};
        tab[6] = '{1'b0, 32'h600, 64'h0,                 8'hFF, 0, 0, 0, 1, 32'h0BADF00D, 32'hFFFFFFFF, 1, 5, 2, 2, 64'h00000000_0BADF00D};
        tab[7] = '{1'b0, 32'h700, 64'h0,                 8'hFF, 1, 4, 0, 0, 32'h11111111, 32'h22222222, 1, 9, 6, 2, 64'h00000000_11111111};
        tab[8] = '{1'b1, 32'h800, 64'h01234567_89ABCDEF, 8'hA5, 0, 3, 0, 0, 32'h0,        32'h0,        0, 8, 5, 2, 64'h0};

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            160'({wb_dat_o, wb_ack_o, wb_err_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}), 160'(0));
        rstn_i = 1;

        for (int i = 0; i < 9; i++) run(tab[i], $sformatf("tab%0d", i));

        // Asynchronous reset while a beat is in ACCESS
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'h900; wb_dat_i = 64'hFFFFFFFF_FFFFFFFF; wb_sel_i = 8'hFF;
        pready_i = 0;
        for (int k = 0; k < 10 && !(psel_o && penable_o); k++) @(negedge clk);
        chk("rst_in_access", 160'(penable_o), 160'(1));
        #2 rstn_i = 0;
        #1 chk("rst_async_outputs",
            160'({wb_dat_o, wb_ack_o, wb_err_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o}), 160'(0));
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge clk);
        rstn_i = 1;
        run(tab[0], "post_rst");

        // WB cycle withdrawn during beat 0: that beat finishes, nothing else happens
        @(negedge clk);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'hA00; wb_dat_i = 64'h55555555_AAAAAAAA; wb_sel_i = 8'hFF;
        nb_d = 0; resp_d = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) resp_d = 1;
            if (psel_o && !penable_o) begin
                nb_d++; wb_cyc_i = 0; wb_stb_i = 0; pready_i = 0;
            end else if (psel_o) begin
                pready_i = 1; pslverr_i = 0;
            end else begin
                pready_i = 0;
            end
        end
        chk("drop_beats", 160'(nb_d), 160'(1));
        chk("drop_no_resp", 160'(resp_d), 160'(0));
        chk("drop_idle", 160'({psel_o, penable_o}), 160'(0));

        for (int i = 0; i < 40; i++) begin
            rv.we  = 1'($urandom);
            rv.adr = $urandom & 32'hFFFF_FFF8;
            rv.dat = {$urandom, $urandom};
            rv.sel = 8'($urandom);
            rv.w0  = $urandom_range(0, 4);
            rv.w1  = $urandom_range(0, 4);
            rv.e0  = $urandom_range(0, 4) == 0;
            rv.e1  = $urandom_range(0, 4) == 0;
            rv.r0  = $urandom;
            rv.r1  = $urandom;
            rv = model(rv);
            run(rv, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
